// File: rtl/spiker_step_controller_if.sv
// Step-controller bus: reg-file start/abort/config/ack, core and writer handshakes.
// master = reg file/core/writer side, slave = controller; clk/rst stay outside.
interface spiker_step_controller_if #(
  parameter int STEP_W = 4
);
  logic              start_i;
  logic              abort_i;
  logic [STEP_W-1:0] n_steps_i;
  logic              core_done_i;
  logic              writer_ready_i;
  logic              sw_ack_i;
  logic              core_clear_o;
  logic              core_start_o;
  logic              sample_o;
  logic              busy_o;
  logic              frame_valid_o;
  logic              err_o;
  logic [STEP_W-1:0] step_cnt_o;

  modport master (
    output start_i, abort_i, n_steps_i,
    output core_done_i, writer_ready_i, sw_ack_i,
    input  core_clear_o, core_start_o, sample_o,
    input  busy_o, frame_valid_o, err_o, step_cnt_o
  );

  modport slave (
    input  start_i, abort_i, n_steps_i,
    input  core_done_i, writer_ready_i, sw_ack_i,
    output core_clear_o, core_start_o, sample_o,
    output busy_o, frame_valid_o, err_o, step_cnt_o
  );
endinterface

// File: rtl/spiker_step_controller.sv
// Sequences one spiking-core frame: clear, N x (start, wait done, sample), hold.
// Ports: clk_i, rst_ni (sync, active-low), bus (slave modport); outputs registered.
module spiker_step_controller #(
  parameter int STEP_W  = 4,
  parameter int TMO_W   = 16,
  parameter int TMO_CYC = 4096
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  spiker_step_controller_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE, CLEAR, STEP, BUSY, WAIT_WR, FRAME, ERR
  } state_e;

  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TMO_CYC - 1);
  localparam logic [TMO_W-1:0]  TMO_ONE  = TMO_W'(1);
  localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);

  state_e            state_q, state_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic [STEP_W-1:0] n_steps_q, n_steps_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic clear_q, clear_d;
  logic start_q, start_d;
  logic sample_q, sample_d;
  logic busy_q, busy_d;
  logic fv_q, fv_d;
  logic err_q, err_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      step_cnt_q <= '0;
      n_steps_q  <= '0;
      tmo_cnt_q  <= '0;
      clear_q    <= 1'b0;
      start_q    <= 1'b0;
      sample_q   <= 1'b0;
      busy_q     <= 1'b0;
      fv_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_cnt_q <= step_cnt_d;
      n_steps_q  <= n_steps_d;
      tmo_cnt_q  <= tmo_cnt_d;
      clear_q    <= clear_d;
      start_q    <= start_d;
      sample_q   <= sample_d;
      busy_q     <= busy_d;
      fv_q       <= fv_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    step_cnt_d = step_cnt_q;
    n_steps_d  = n_steps_q;
    tmo_cnt_d  = tmo_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          if (bus.n_steps_i != '0) begin
            n_steps_d  = bus.n_steps_i;
            step_cnt_d = '0;
            state_d    = CLEAR;
          end else begin
            state_d = ERR;
          end
        end
      end
      CLEAR: state_d = STEP;
      STEP: begin
        tmo_cnt_d = '0;
        state_d   = BUSY;
      end
      BUSY: begin
        tmo_cnt_d = tmo_cnt_q + TMO_ONE;
        if (bus.core_done_i) begin
          state_d = WAIT_WR;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d = ERR;
        end
      end
      WAIT_WR: begin
        if (bus.writer_ready_i) begin
          step_cnt_d = step_cnt_q + STEP_ONE;
          state_d = (step_cnt_d == n_steps_q) ? FRAME : STEP;
        end
      end
      FRAME: begin
        if (bus.sw_ack_i) begin
          state_d = IDLE;
        end
      end
      ERR: state_d = ERR;
      default: state_d = IDLE;
    endcase
    // Abort freezes the datapath too, so a same-cycle sample never counts.
    if (bus.abort_i) begin
      state_d    = IDLE;
      step_cnt_d = step_cnt_q;
      n_steps_d  = n_steps_q;
      tmo_cnt_d  = tmo_cnt_q;
    end
  end

  // Decoded from the next state so every flag lands with its state.
  always_comb begin
    clear_d  = (state_d == CLEAR);
    start_d  = (state_d == STEP);
    sample_d = (state_q == WAIT_WR) && bus.writer_ready_i
               && !bus.abort_i;
    busy_d   = (state_d == CLEAR) || (state_d == STEP)
               || (state_d == BUSY) || (state_d == WAIT_WR);
    fv_d     = (state_d == FRAME);
    err_d    = (state_d == ERR);
  end

  assign bus.core_clear_o  = clear_q;
  assign bus.core_start_o  = start_q;
  assign bus.sample_o      = sample_q;
  assign bus.busy_o        = busy_q;
  assign bus.frame_valid_o = fv_q;
  assign bus.err_o         = err_q;
  assign bus.step_cnt_o    = step_cnt_q;
endmodule

// File: tb/tb_spiker_step_controller.sv
// Bench for spiker_step_controller: event-time model of a frame vs DUT outputs.
// Observed vector = {clear,start,sample,busy,frame_valid,err,step_cnt}.
module tb_spiker_step_controller;
  localparam int STEP_W = 4;
  localparam int TMO_W  = 16;
  localparam int TMO    = 4096;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   dq[16];
  int   wq[16];

  always #5 clk = ~clk;

  spiker_step_controller_if #(.STEP_W(STEP_W)) bus();

  spiker_step_controller #(
    .STEP_W (STEP_W),
    .TMO_W  (TMO_W),
    .TMO_CYC(TMO)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  function automatic logic [9:0] obs();
    return {bus.core_clear_o, bus.core_start_o, bus.sample_o,
            bus.busy_o, bus.frame_valid_o, bus.err_o,
            bus.step_cnt_o};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start_i        = 1'b0;
    bus.abort_i        = 1'b0;
    bus.n_steps_i      = '0;
    bus.core_done_i    = 1'b0;
    bus.writer_ready_i = 1'b0;
    bus.sw_ack_i       = 1'b0;
  endtask

  task automatic fill(input int dmax, input int wmax);
    for (int i = 0; i < 16; i++) begin
      dq[i] = $urandom_range(1, dmax);
      wq[i] = $urandom_range(0, wmax);
    end
  endtask

  // Step i: start at s[i], done after dq[i], ready wq[i] later,
  // sample (and next start) at s[i]+dq[i]+wq[i]+2.
  // mode 0: full frame + ack; 1: abort at cut_t; 2: reset at cut_t.
  task automatic run_frame(input string name, input int n,
                           input int mode, input int cut_t,
                           input bit noise);
    int s[16];
    int smp[16];
    int f;
    int ack_t;
    int last;
    int cut;
    int cnt;
    bit is_s;
    bit is_smp;
    bit done_v;
    bit rdy_v;
    logic [9:0] exp;
    logic [9:0] got;
    s[0] = 2;
    for (int i = 0; i < n; i++) begin
      smp[i] = s[i] + dq[i] + wq[i] + 2;
      if (i + 1 < n) s[i+1] = smp[i];
    end
    f = smp[n-1];
    ack_t = f + int'($urandom_range(0, 4));
    last = (mode != 0) ? cut_t + 4 : ack_t + 3;
    cut = (mode != 0) ? cut_t : last + 1;
    bus.n_steps_i = STEP_W'(n);
    bus.start_i = 1'b1;
    for (int t = 1; t <= last; t++) begin
      tick();
      cnt = 0;
      is_s = 1'b0;
      is_smp = 1'b0;
      for (int i = 0; i < n; i++) begin
        if (smp[i] <= t && smp[i] <= cut) cnt++;
        if (s[i] == t) is_s = 1'b1;
        if (smp[i] == t) is_smp = 1'b1;
      end
      if (t > cut)
        exp = {6'b0, (mode == 1) ? 4'(cnt) : 4'd0};
      else if (t > ack_t)
        exp = {6'b0, 4'(n)};
      else
        exp = {t == 1, is_s, is_smp, t < f, t >= f,
               1'b0, 4'(cnt)};
      got = obs();
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL %s t=%0d: got %b want %b",
                 name, t, got, exp);
      end
      done_v = 1'b0;
      rdy_v = 1'b0;
      for (int i = 0; i < n; i++) begin
        if (t == s[i] + dq[i]) done_v = 1'b1;
        if (t == s[i] + dq[i] + 1 + wq[i]) rdy_v = 1'b1;
      end
      if (t >= cut) begin
        done_v = 1'b0;
        rdy_v = 1'b0;
      end
      bus.core_done_i = done_v;
      bus.writer_ready_i = rdy_v;
      bus.n_steps_i = STEP_W'($urandom);
      bus.start_i = noise && t < f && t < cut
                    && ($urandom_range(0, 3) == 0);
      bus.sw_ack_i = (mode == 0 && t == ack_t)
                     || (noise && t < f && t < cut
                         && ($urandom_range(0, 3) == 0));
      bus.abort_i = (mode == 1 && t == cut);
      rst_n = !(mode == 2 && t == cut);
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (obs() !== 10'b0) begin
      n_bad++;
      $display("FAIL reset: got %b want %b", obs(), 10'b0);
    end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (obs() !== 10'b0) begin
      n_bad++;
      $display("FAIL post_reset: got %b want %b", obs(), 10'b0);
    end
  endtask

  task automatic test_three_steps();
    for (int i = 0; i < 16; i++) begin
      dq[i] = 5;
      wq[i] = 0;
    end
    run_frame("t1_three", 3, 0, 0, 1'b0);
  endtask

  task automatic test_writer_stall();
    fill(6, 0);
    wq[0] = 10;
    wq[1] = 10;
    run_frame("t2_stall", 2, 0, 0, 1'b0);
  endtask

  task automatic test_timeout();
    logic [9:0] exp;
    logic [9:0] got;
    bus.n_steps_i = 4'd1;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    n_cmp++;
    if (obs() !== 10'b1001000000) begin
      n_bad++;
      $display("FAIL tmo_clear: got %b want %b",
               obs(), 10'b1001000000);
    end
    tick();
    for (int t = 3; t <= 3 + TMO; t++) begin
      tick();
      got = obs();
      exp = {3'b0, t < 3 + TMO, 1'b0, t == 3 + TMO, 4'd0};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL tmo t=%0d: got %b want %b", t, got, exp);
      end
    end
    bus.start_i = 1'b1;
    bus.n_steps_i = 4'd5;
    bus.sw_ack_i = 1'b1;
    tick();
    idle_inputs();
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (obs() !== 10'b0000010000) begin
        n_bad++;
        $display("FAIL err_hold: got %b want %b",
                 obs(), 10'b0000010000);
      end
      tick();
    end
    bus.abort_i = 1'b1;
    tick();
    bus.abort_i = 1'b0;
    n_cmp++;
    if (obs() !== 10'b0) begin
      n_bad++;
      $display("FAIL err_abort: got %b want %b", obs(), 10'b0);
    end
  endtask

  task automatic test_zero_steps();
    logic [9:0] got;
    bus.n_steps_i = '0;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      got = obs();
      n_cmp++;
      if (got[9:4] !== 6'b000001) begin
        n_bad++;
        $display("FAIL zero_start: got %b want %b",
                 got[9:4], 6'b000001);
      end
      tick();
    end
    bus.abort_i = 1'b1;
    tick();
    bus.abort_i = 1'b0;
    got = obs();
    n_cmp++;
    if (got[9:4] !== 6'b0) begin
      n_bad++;
      $display("FAIL zero_abort: got %b want %b",
               got[9:4], 6'b0);
    end
    fill(4, 2);
    run_frame("t4_fifteen", 15, 0, 0, 1'b0);
  endtask

  task automatic test_abort();
    fill(8, 5);
    run_frame("t5_abort", 4, 1, 2 + dq[0] + wq[0] + 2 + 1, 1'b0);
  endtask

  task automatic test_reset_mid();
    fill(4, 2);
    dq[0] = 3;
    wq[0] = 4;
    run_frame("t5_reset", 2, 2, 2 + 3 + 1, 1'b0);
  endtask

  task automatic test_ignored();
    fill(8, 3);
    run_frame("t6_ignored", 2, 0, 0, 1'b1);
  endtask

  task automatic test_timeout_race();
    dq[0] = TMO;
    wq[0] = 0;
    run_frame("t6_race", 1, 0, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 12; k++) begin
      fill(8, 5);
      run_frame("random", $urandom_range(1, 15), 0, 0, 1'b1);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_three_steps();
    test_writer_stall();
    test_timeout();
    test_zero_steps();
    test_abort();
    test_reset_mid();
    test_ignored();
    test_timeout_race();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
